// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared types and default widths for the program loader
package sap_pkg;

    localparam int ADR_W_DEF  = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FULL  = 3'd3,
        ST_RUN   = 3'd4
    } ld_state_t;

endpackage

// File: rtl/load_ctrl_if.sv
// rtl/load_ctrl_if.sv - loader stream, CPU request and memory port bundle
interface load_ctrl_if #(
    parameter int ADR_W  = sap_pkg::ADR_W_DEF,
    parameter int DATA_W = sap_pkg::DATA_W_DEF
);
    logic              run_req;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADR_W-1:0]  cpu_adr;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_data;
    logic [ADR_W-1:0]  mem_adr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_hold;
    logic [ADR_W:0]    load_count;
    logic              load_full;

    modport master (
        output run_req, ld_start, ld_valid, ld_data, cpu_adr, cpu_write, cpu_data,
        input  ld_ready, mem_adr, mem_write, mem_data, cpu_hold, load_count, load_full
    );

    modport slave (
        input  run_req, ld_start, ld_valid, ld_data, cpu_adr, cpu_write, cpu_data,
        output ld_ready, mem_adr, mem_write, mem_data, cpu_hold, load_count, load_full
    );
endinterface

// File: rtl/load_ctrl_clkdiv.sv
// rtl/load_ctrl_clkdiv.sv - one-sysclk clock-enable tick every i_period cycles
module load_ctrl_clkdiv #(
    parameter int W = 4
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_period,
    output logic         o_tick
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == i_period - 1'b1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == '0);
endmodule

// File: rtl/load_ctrl.sv
// rtl/load_ctrl.sv - arbitrates program memory between a byte loader and the CPU
module load_ctrl
    import sap_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       clken,
    load_ctrl_if.slave bus
);
    localparam logic [ADR_W-1:0] PTR_MAX = '1;
    localparam logic [ADR_W:0]   CNT_MAX = {1'b1, {ADR_W{1'b0}}};

    ld_state_t         r_state, w_state_nxt;
    logic [ADR_W-1:0]  r_ptr, w_ptr_nxt;
    logic [DATA_W-1:0] r_byte, w_byte_nxt;
    logic [ADR_W:0]    r_count, w_count_nxt;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_byte  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_byte  <= w_byte_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_byte_nxt  = r_byte;
        w_count_nxt = r_count;
        if (clken) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.run_req) begin
                        w_state_nxt = ST_RUN;
                    end else if (bus.ld_start) begin
                        w_state_nxt = ST_LOAD;
                        w_ptr_nxt   = '0;
                        w_count_nxt = '0;
                    end
                end
                ST_LOAD: begin
                    // A restart wins over a byte; a byte wins over leaving for RUN
                    if (bus.ld_start && !bus.run_req) begin
                        w_ptr_nxt   = '0;
                        w_count_nxt = '0;
                    end else if (bus.ld_valid) begin
                        w_byte_nxt  = bus.ld_data;
                        w_state_nxt = ST_WRITE;
                    end else if (bus.run_req) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_WRITE: begin
                    w_count_nxt = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
                    if (r_ptr == PTR_MAX) begin
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_ptr_nxt   = r_ptr + 1'b1;
                        w_state_nxt = bus.run_req ? ST_RUN : ST_LOAD;
                    end
                end
                ST_FULL: begin
                    if (bus.run_req) begin
                        w_state_nxt = ST_RUN;
                    end else if (bus.ld_start) begin
                        w_state_nxt = ST_LOAD;
                        w_ptr_nxt   = '0;
                        w_count_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (!bus.run_req) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_adr   = r_ptr;
        bus.mem_write = 1'b0;
        bus.mem_data  = r_byte;
        bus.cpu_hold  = 1'b1;
        bus.ld_ready  = 1'b0;
        case (r_state)
            ST_LOAD:  bus.ld_ready = 1'b1;
            ST_WRITE: bus.mem_write = 1'b1;
            ST_RUN: begin
                bus.mem_adr   = bus.cpu_adr;
                bus.mem_write = bus.cpu_write;
                bus.mem_data  = bus.cpu_data;
                bus.cpu_hold  = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.load_count = r_count;
    assign bus.load_full  = (r_count == CNT_MAX);
endmodule

// File: doc/load_ctrl.md
LOAD_CTRL -- requirements
Module: load_ctrl

Interface
REQ-001 Parameter ADR_W, default 4, memory address width (16 words).
REQ-002 Parameter DATA_W, default 8, memory word width.
REQ-003 sysclk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 clken  in  1  one-sysclk-wide clock-enable tick; FSM, pointer and handshake advance only on sysclk edges where clken=1.
REQ-006 run_req  in  1  level: 1 = CPU owns memory, 0 = programming mode.
REQ-007 ld_start  in  1  request to begin a new load from address 0.
REQ-008 ld_valid  in  1  loader byte valid.
REQ-009 ld_data  in  DATA_W  loader byte.
REQ-010 ld_ready  out  1  controller accepts a byte this tick.
REQ-011 cpu_adr, cpu_write, cpu_data  in  ADR_W, 1, DATA_W  CPU memory request.
REQ-012 mem_adr, mem_write, mem_data  out  ADR_W, 1, DATA_W  drive memory adr, write, data_in.
REQ-013 cpu_hold  out  1  CPU stalled (memory not owned by CPU).
REQ-014 load_count  out  ADR_W+1  bytes written since last ld_start.
REQ-015 load_full  out  1  all 2**ADR_W words written.

Function
REQ-016 States IDLE, LOAD, WRITE, FULL, RUN; FSM shall hold when clken=0.
REQ-017 IDLE: ld_start -> LOAD with ptr=0, load_count=0; run_req=1 -> RUN; run_req takes priority over ld_start.
REQ-018 LOAD: ld_ready=1; ld_valid=1 on tick -> latch ld_data into byte register, go WRITE; run_req=1 (no ld_valid) -> RUN; ld_valid and run_req together -> byte accepted, WRITE first.
REQ-019 WRITE: mem_write=1, mem_adr=ptr, mem_data=byte register for exactly one clken period; on next tick load_count+1; ptr=max -> FULL, else ptr+1 and -> LOAD (or RUN if run_req=1).
REQ-020 FULL: load_full=1, ld_ready=0; ld_start -> LOAD restarting at 0; run_req=1 -> RUN.
REQ-021 RUN: mem_adr/mem_write/mem_data combinationally equal cpu_* inputs; cpu_hold=0; ld_ready=0; ld_start ignored; run_req=0 on tick -> IDLE.
REQ-022 Outside RUN, cpu_write shall never reach mem_write; cpu_hold=1.
REQ-023 Outside WRITE and RUN, mem_write=0 and mem_adr=ptr.
REQ-024 ptr shall not wrap: no write beyond max address without a fresh ld_start.
REQ-025 ld_ready shall be registered-state-derived (no combinational path from ld_valid).
REQ-026 ld_start in LOAD restarts (ptr=0, load_count=0) without writing; ld_start in WRITE is ignored.
REQ-027 load_count saturates at 2**ADR_W.

Reset
REQ-028 reset=0 asynchronously forces IDLE, ptr=0, byte register=0, load_count=0.
REQ-029 During and after reset: ld_ready=0, mem_write=0, mem_adr=0, mem_data=0, cpu_hold=1, load_full=0.
REQ-030 Reset in WRITE shall drop mem_write immediately; the partial write is not counted.

Structure
REQ-031 State encoding enum and ADR_W/DATA_W defaults in shared package sap_pkg.
REQ-032 One sub-module natural: existing clocken divider instantiated in the bench only, not inside load_ctrl.
REQ-033 Single FSM process plus one output mux; no internal memory.

Verification
REQ-034 Reset, ld_start, feed 8'h1E,8'h2F at adr 0,1 -> one mem_write period each, mem_adr 0 then 1, load_count=2.
REQ-035 Load 16 bytes 8'h00..8'h0F -> load_full=1 after 16th write, ld_ready=0, 17th ld_valid causes no write.
REQ-036 run_req=1 mid-load while in WRITE -> write to current ptr completes, then RUN; cpu_adr=4'h3 appears on mem_adr, cpu_hold=0.
REQ-037 RUN, then run_req=0 with cpu_write=1 -> IDLE on next tick, mem_write=0 thereafter.
REQ-038 reset=0 asserted mid-WRITE (asynchronous to clken) -> mem_write=0 same cycle, load_count=0.
REQ-039 ld_valid held high with clken gap of 10 sysclk -> exactly one byte accepted per clken tick, none between.
